mat_reg_loader: RTL and testbench
=================================

MAT_REG_LOADER -- requirements
Module: mat_reg_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 128, meaning matrix dimension in shortreal elements.
REQ-002 SHALL have parameter WIDTH_ADDR_SIZE, default $clog2(WIDTH), meaning row/column index width.
REQ-003 SHALL have port clock  input  1  single clock; all logic updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a load, sampled in IDLE only.
REQ-006 SHALL have port start_col  input  1  0 = load rows, 1 = load columns; sampled with start.
REQ-007 SHALL have port start_count  input  WIDTH_ADDR_SIZE+1  number of vectors to load, 0..WIDTH; sampled with start.
REQ-008 SHALL have port in_valid  input  1  upstream vector valid.
REQ-009 SHALL have port in_ready  output  1  loader accepts vector this cycle.
REQ-010 SHALL have port in_data  input  shortreal[WIDTH]  upstream vector.
REQ-011 SHALL have port write_op  output  MatDataWriteOp_t  write command to matrix register.
REQ-012 SHALL have port write_param1  output  WIDTH_ADDR_SIZE  target row/column index.
REQ-013 SHALL have port write_param2  output  WIDTH_ADDR_SIZE  held at 0.
REQ-014 SHALL have port data_out  output  shortreal[WIDTH]  vector driven to matrix register data_in.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at load completion.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, LOAD, DONE.
REQ-018 IDLE: start=1 SHALL latch start_col and start_count, clear index counter to 0, and go to CLEAR if MAT_REG_LOADER_CLEAR_EN is defined, else LOAD (DONE if start_count==0).
REQ-019 CLEAR SHALL last exactly one cycle, drive write_op=MAT_DATA_WRITE_ZERO on the next cycle, then go to LOAD (DONE if count==0).
REQ-020 in_ready SHALL be 1 only in LOAD; a beat is accepted when in_valid && in_ready at a posedge.
REQ-021 An accepted beat SHALL produce, on the following cycle only, write_op=MAT_DATA_WRITE_ROW (start_col=0) or MAT_DATA_WRITE_COL (start_col=1), write_param1=current index, data_out=accepted in_data (all registered, 1-cycle latency).
REQ-022 Index SHALL increment by 1 per accepted beat; accepting beat number count-1 SHALL move the FSM to DONE.
REQ-023 in_valid=0 in LOAD SHALL stall with no state change and write_op=MAT_DATA_WRITE_DISABLE next cycle.
REQ-024 DONE SHALL last one cycle with done=1, coinciding with the final write_op cycle, then return to IDLE.
REQ-025 write_op SHALL be MAT_DATA_WRITE_DISABLE in every cycle not covered by REQ-019/REQ-021.
REQ-026 start asserted while busy SHALL be ignored; latched mode and count SHALL remain unchanged.
REQ-027 start_count>WIDTH SHALL be saturated to WIDTH; index never exceeds WIDTH-1.
REQ-028 data_out SHALL hold its last value when write_op is DISABLE.

Reset
REQ-029 reset=1 SHALL, at the next posedge, force IDLE, index=0, write_op=MAT_DATA_WRITE_DISABLE, write_param1=0, write_param2=0, data_out all 0.0, busy=0, done=0, in_ready=0.
REQ-030 reset mid-load SHALL abandon the load without a done pulse; partially written matrix contents are not restored.
REQ-031 reset SHALL take priority over start and in_valid in the same cycle.

Configuration
REQ-032 With macro MAT_REG_LOADER_CLEAR_EN defined, the CLEAR state and ZERO command SHALL be present (load latency +1 cycle).
REQ-033 Without MAT_REG_LOADER_CLEAR_EN, CLEAR SHALL be absent and IDLE SHALL go directly to LOAD; unwritten matrix entries keep prior values.

Verification
REQ-034 Reset, then start, start_col=0, count=4, in_valid held 1 with vectors v0..v3 -> write_op=ROW with write_param1=0,1,2,3 on 4 consecutive cycles, done=1 with index-3 write, busy low after.
REQ-035 start_col=1, count=2, in_valid toggling 1,0,1 -> COL index 0, DISABLE, COL index 1; no done before the second write.
REQ-036 start, count=0 -> no ROW/COL writes; done pulses within 2 cycles (3 with CLEAR_EN); in_ready never 1.
REQ-037 start pulsed again during load of count=3 -> exactly 3 writes, single done pulse.
REQ-038 reset asserted after 2 of 5 beats -> next cycle write_op=DISABLE, busy=0, no done pulse; fresh start loads from index 0.
REQ-039 With MAT_REG_LOADER_CLEAR_EN defined, start count=1 -> ZERO issued one cycle before the single ROW write; without the macro, no ZERO is ever issued.

Source files
------------

// File: rtl/mat_reg_loader_if.sv
// Write-command encoding shared with the matrix register, plus the upstream
// vector handshake bundle consumed by mat_reg_loader.
package mat_reg_loader_pkg;
    typedef enum logic [1:0] {
        MAT_DATA_WRITE_DISABLE = 2'd0,
        MAT_DATA_WRITE_ZERO    = 2'd1,
        MAT_DATA_WRITE_ROW     = 2'd2,
        MAT_DATA_WRITE_COL     = 2'd3
    } MatDataWriteOp_t;
endpackage

interface mat_reg_loader_if #(
    parameter int WIDTH = 128
);
    // Each lane carries one IEEE-754 single-precision (shortreal) bit pattern.
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0][31:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/mat_reg_loader.sv
// Streams start_count row/column vectors into a matrix register, one write per accepted beat.
// Optional macro MAT_REG_LOADER_CLEAR_EN adds a CLEAR state that issues a ZERO command first.
module mat_reg_loader
    import mat_reg_loader_pkg::*;
#(
    parameter int WIDTH           = 128,
    parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         start_col,
    input  logic [WIDTH_ADDR_SIZE:0]     start_count,
    mat_reg_loader_if.slave              in_bus,
    output MatDataWriteOp_t              write_op,
    output logic [WIDTH_ADDR_SIZE-1:0]   write_param1,
    output logic [WIDTH_ADDR_SIZE-1:0]   write_param2,
    output logic [WIDTH-1:0][31:0]       data_out,
    output logic                         busy,
    output logic                         done
);
    localparam int CW = WIDTH_ADDR_SIZE + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
`ifdef MAT_REG_LOADER_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    state_t                       state, state_next;
    logic                         col_q, col_next;
    logic [CW-1:0]                cnt_q, cnt_next;
    logic [WIDTH_ADDR_SIZE-1:0]   idx_q, idx_next;
    MatDataWriteOp_t              op_next;
    logic [WIDTH_ADDR_SIZE-1:0]   p1_next;
    logic [WIDTH-1:0][31:0]       data_next;
    logic [CW-1:0]                cnt_sat;
    logic                         last_beat;

    assign cnt_sat   = (start_count > CW'(WIDTH)) ? CW'(WIDTH) : start_count;
    assign last_beat = (CW'(idx_q) + CW'(1)) == cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            col_q        <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            write_op     <= MAT_DATA_WRITE_DISABLE;
            write_param1 <= '0;
            data_out     <= '0;
        end else begin
            state        <= state_next;
            col_q        <= col_next;
            cnt_q        <= cnt_next;
            idx_q        <= idx_next;
            write_op     <= op_next;
            write_param1 <= p1_next;
            data_out     <= data_next;
        end
    end

    always_comb begin
        state_next = state;
        col_next   = col_q;
        cnt_next   = cnt_q;
        idx_next   = idx_q;
        op_next    = MAT_DATA_WRITE_DISABLE;
        p1_next    = write_param1;
        data_next  = data_out;

        unique case (state)
            IDLE: begin
                if (start) begin
                    col_next = start_col;
                    cnt_next = cnt_sat;
                    idx_next = '0;
`ifdef MAT_REG_LOADER_CLEAR_EN
                    state_next = CLEAR;
`else
                    state_next = (cnt_sat == '0) ? DONE : LOAD;
`endif
                end
            end
`ifdef MAT_REG_LOADER_CLEAR_EN
            CLEAR: begin
                op_next    = MAT_DATA_WRITE_ZERO;
                state_next = (cnt_q == '0) ? DONE : LOAD;
            end
`endif
            LOAD: begin
                if (in_bus.in_valid) begin
                    op_next   = col_q ? MAT_DATA_WRITE_COL : MAT_DATA_WRITE_ROW;
                    p1_next   = idx_q;
                    data_next = in_bus.in_data;
                    // Index stays put on the final beat so it never passes WIDTH-1.
                    if (last_beat) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx_q + WIDTH_ADDR_SIZE'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_bus.in_ready = (state == LOAD);
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign write_param2    = '0;
endmodule

// File: tb/tb_mat_reg_loader.sv
// Randomized bench for mat_reg_loader: each load is expanded into an expected per-cycle timeline.
module tb_mat_reg_loader;
    import mat_reg_loader_pkg::*;

    localparam int W    = 8;
    localparam int AW   = $clog2(W);
    localparam int MAXC = 64;
`ifdef MAT_REG_LOADER_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 start_col;
    logic [AW:0]          start_count;
    MatDataWriteOp_t      write_op;
    logic [AW-1:0]        write_param1;
    logic [AW-1:0]        write_param2;
    logic [W-1:0][31:0]   data_out;
    logic                 busy;
    logic                 done;

    mat_reg_loader_if #(.WIDTH(W)) bus ();

    mat_reg_loader #(.WIDTH(W), .WIDTH_ADDR_SIZE(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .start_col    (start_col),
        .start_count  (start_count),
        .in_bus       (bus),
        .write_op     (write_op),
        .write_param1 (write_param1),
        .write_param2 (write_param2),
        .data_out     (data_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Last vector written to the matrix register; data_out must keep showing it.
    logic [W-1:0][31:0] last_data;

    MatDataWriteOp_t    e_op    [MAXC];
    logic               e_busy  [MAXC];
    logic               e_ready [MAXC];
    logic               e_done  [MAXC];
    logic [AW-1:0]      e_p1    [MAXC];
    logic               e_p1chk [MAXC];
    logic [W-1:0][31:0] e_data  [MAXC];
    logic               e_dchk  [MAXC];
    logic               v       [MAXC];
    logic [W-1:0][31:0] d       [MAXC];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [W-1:0][31:0] rand_vec();
        logic [W-1:0][31:0] r;
        for (int i = 0; i < W; i++) r[i] = $urandom;
        return r;
    endfunction

    task automatic check_cycle(input int t);
        check($sformatf("busy[%0d]", t),  256'(busy),          256'(e_busy[t]));
        check($sformatf("ready[%0d]", t), 256'(bus.in_ready),  256'(e_ready[t]));
        check($sformatf("done[%0d]", t),  256'(done),          256'(e_done[t]));
        check($sformatf("op[%0d]", t),    256'(write_op),      256'(e_op[t]));
        check($sformatf("p2[%0d]", t),    256'(write_param2),  256'(0));
        if (e_p1chk[t]) check($sformatf("p1[%0d]", t), 256'(write_param1), 256'(e_p1[t]));
        if (e_dchk[t])  check($sformatf("data[%0d]", t), 256'(data_out), 256'(e_data[t]));
    endtask

    // vmode: 0 = in_valid held high, 1 = toggling 1,0,1..., 2 = random.
    task automatic run_txn(input logic col, input int cnt_raw, input int vmode, input logic noise);
        int n, first, c, k, t_end;
        logic [W-1:0][31:0] hold;
        n     = (cnt_raw > W) ? W : cnt_raw;
        first = 1 + CLR;
        for (int t = 0; t < MAXC; t++) begin
            d[t]       = rand_vec();
            e_op[t]    = MAT_DATA_WRITE_DISABLE;
            e_busy[t]  = 1'b0;
            e_ready[t] = 1'b0;
            e_done[t]  = 1'b0;
            e_p1[t]    = '0;
            e_p1chk[t] = 1'b0;
            e_data[t]  = '0;
            if (t < first)        v[t] = 1'($urandom_range(1));
            else if (vmode == 0)  v[t] = 1'b1;
            else if (vmode == 1)  v[t] = ((t - first) % 2) == 0;
            else                  v[t] = (t >= 40) || ($urandom_range(3) != 0);
        end
        if (CLR == 1) begin
            e_busy[1]     = 1'b1;
            e_op[first]   = MAT_DATA_WRITE_ZERO;
        end
        if (n == 0) begin
            e_busy[first] = 1'b1;
            e_done[first] = 1'b1;
            t_end = first + 1;
        end else begin
            c = first;
            k = 0;
            while (k < n) begin
                e_busy[c]  = 1'b1;
                e_ready[c] = 1'b1;
                if (v[c]) begin
                    e_op[c+1]    = col ? MAT_DATA_WRITE_COL : MAT_DATA_WRITE_ROW;
                    e_p1[c+1]    = AW'(k);
                    e_p1chk[c+1] = 1'b1;
                    e_data[c+1]  = d[c];
                    k++;
                end
                c++;
            end
            e_busy[c] = 1'b1;
            e_done[c] = 1'b1;
            t_end = c + 1;
        end
        hold = last_data;
        for (int t = 0; t <= t_end; t++) begin
            if (e_op[t] == MAT_DATA_WRITE_ROW || e_op[t] == MAT_DATA_WRITE_COL) hold = e_data[t];
            else e_data[t] = hold;
            e_dchk[t] = (e_op[t] != MAT_DATA_WRITE_ZERO);
        end

        for (int t = 0; t <= t_end; t++) begin
            if (t == 0) begin
                start       = 1'b1;
                start_col   = col;
                start_count = (AW+1)'(cnt_raw);
            end else begin
                start       = noise && (t < t_end) && ($urandom_range(1) == 1);
                start_col   = 1'($urandom_range(1));
                start_count = (AW+1)'($urandom_range(15));
            end
            bus.in_valid = v[t];
            bus.in_data  = d[t];
            @(negedge clock);
            check_cycle(t);
            @(posedge clock);
            #1;
        end
        start     = 1'b0;
        last_data = hold;
    endtask

    // Reset after two of five beats, together with start and in_valid.
    task automatic reset_mid_load();
        int first;
        first = 1 + CLR;
        for (int t = 0; t <= first + 3; t++) begin
            start        = (t == 0) || (t == first + 2);
            start_col    = 1'b0;
            start_count  = (AW+1)'(5);
            bus.in_valid = (t >= first);
            bus.in_data  = rand_vec();
            reset        = (t == first + 2);
            if (t == first) d[0] = bus.in_data;
            @(negedge clock);
            if (t == first + 2) begin
                check("rst_pre_op",   256'(write_op),     256'(MAT_DATA_WRITE_ROW));
                check("rst_pre_p1",   256'(write_param1), 256'(1));
                check("rst_pre_done", 256'(done),         256'(0));
            end
            if (t == first + 1) check("rst_pre_d0", 256'(data_out), 256'(d[0]));
            if (t == first + 3) begin
                check("rst_op",    256'(write_op),     256'(MAT_DATA_WRITE_DISABLE));
                check("rst_busy",  256'(busy),         256'(0));
                check("rst_done",  256'(done),         256'(0));
                check("rst_ready", 256'(bus.in_ready), 256'(0));
                check("rst_p1",    256'(write_param1), 256'(0));
                check("rst_data",  256'(data_out),     256'(0));
            end
            @(posedge clock);
            #1;
        end
        reset     = 1'b0;
        start     = 1'b0;
        last_data = '0;
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b1;
        start_col    = 1'b0;
        start_count  = (AW+1)'(3);
        bus.in_valid = 1'b1;
        bus.in_data  = rand_vec();
        last_data    = '0;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("init_busy",  256'(busy),         256'(0));
        check("init_done",  256'(done),         256'(0));
        check("init_ready", 256'(bus.in_ready), 256'(0));
        check("init_op",    256'(write_op),     256'(MAT_DATA_WRITE_DISABLE));
        check("init_p1",    256'(write_param1), 256'(0));
        check("init_data",  256'(data_out),     256'(0));
        @(posedge clock);
        #1;
        reset        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;

        run_txn(1'b0, 4, 0, 1'b0);
        run_txn(1'b1, 2, 1, 1'b0);
        run_txn(1'b0, 0, 2, 1'b0);
        run_txn(1'b1, 3, 2, 1'b1);
        run_txn(1'b0, 15, 0, 1'b0);
        run_txn(1'b1, W, 2, 1'b1);
        run_txn(1'b0, 1, 0, 1'b0);
        reset_mid_load();
        run_txn(1'b0, 3, 0, 1'b0);
        for (int i = 0; i < 25; i++) begin
            run_txn(1'($urandom_range(1)), int'($urandom_range(15)), 2, 1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
